// File: rtl/sisc_ctrl_seq_pkg.sv
// Shared encodings for the SISC control sequencer: FSM states, opcodes,
// decoded opcode classes and the alu_op/wb_sel codes.
package sisc_pkg;

  typedef enum logic [2:0] {
    S_START0, S_START1, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    C_NOOP, C_LOD, C_STR, C_SWP, C_BRA, C_BRR, C_BNE, C_BNR, C_ALU, C_HLT, C_ILL
  } op_cls_e;

  localparam int OP_NOOP = 0;
  localparam int OP_LOD  = 1;
  localparam int OP_STR  = 2;
  localparam int OP_SWP  = 3;
  localparam int OP_BRA  = 4;
  localparam int OP_BRR  = 5;
  localparam int OP_BNE  = 6;
  localparam int OP_BNR  = 7;
  localparam int OP_ALU  = 8;
  localparam int OP_HLT  = 15;

  localparam int AM_IMM_DEF = 8;

  localparam logic [1:0] ALU_REG  = 2'b00;
  localparam logic [1:0] ALU_IMM  = 2'b01;
  localparam logic [1:0] ALU_DEF  = 2'b10;
  localparam logic [1:0] ALU_ADDR = 2'b11;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_SWPA = 2'b10;
  localparam logic [1:0] WB_SWPB = 2'b11;

  // Undefined opcodes collapse to C_ILL, which sequences exactly like NOOP.
  function automatic op_cls_e decode_op(input logic [31:0] op);
    case (op)
      OP_NOOP: return C_NOOP;
      OP_LOD:  return C_LOD;
      OP_STR:  return C_STR;
      OP_SWP:  return C_SWP;
      OP_BRA:  return C_BRA;
      OP_BRR:  return C_BRR;
      OP_BNE:  return C_BNE;
      OP_BNR:  return C_BNR;
      OP_ALU:  return C_ALU;
      OP_HLT:  return C_HLT;
      default: return C_ILL;
    endcase
  endfunction

endpackage

// File: rtl/sisc_ctrl_seq_if.sv
// Control bus between the SISC datapath and its sequencer.
// dm_ack only exists when SISC_CTRL_MEMWAIT_EN is defined.
interface sisc_ctrl_seq_if #(
  parameter int OP_W   = 4,
  parameter int MM_W   = 4,
  parameter int STAT_W = 4,
  parameter int CNT_W  = 16
);
  logic [OP_W-1:0]   opcode;
  logic [MM_W-1:0]   mm;
  logic [STAT_W-1:0] stat;
  logic              hold;
`ifdef SISC_CTRL_MEMWAIT_EN
  logic              dm_ack;
`endif
  logic              rf_we, ir_load, pc_write, pc_rst, dm_we;
  logic              pc_sel, br_sel, rb_sel, mm_sel, rw_sel;
  logic [1:0]        alu_op, wb_sel;
  logic              halted, illegal_op;
  logic [CNT_W-1:0]  retired;

  modport master (
    output opcode, mm, stat, hold,
`ifdef SISC_CTRL_MEMWAIT_EN
    output dm_ack,
`endif
    input  rf_we, ir_load, pc_write, pc_rst, dm_we,
    input  pc_sel, br_sel, rb_sel, mm_sel, rw_sel,
    input  alu_op, wb_sel, halted, illegal_op, retired
  );

  modport slave (
    input  opcode, mm, stat, hold,
`ifdef SISC_CTRL_MEMWAIT_EN
    input  dm_ack,
`endif
    output rf_we, ir_load, pc_write, pc_rst, dm_we,
    output pc_sel, br_sel, rb_sel, mm_sel, rw_sel,
    output alu_op, wb_sel, halted, illegal_op, retired
  );
endinterface

// File: rtl/sisc_br_cond.sv
// Branch condition: BRA/BRR take on any masked status bit, BNE/BNR on none.
module sisc_br_cond
  import sisc_pkg::*;
#(
  parameter int OP_W = 4,
  parameter int W    = 4
) (
  input  logic [OP_W-1:0] i_opcode,
  input  logic [W-1:0]    i_stat,
  input  logic [W-1:0]    i_mm,
  output logic            o_taken
);
  logic    w_any;
  op_cls_e w_cls;

  assign w_any = |(i_stat & i_mm);
  assign w_cls = decode_op(32'(i_opcode));

  always_comb begin
    o_taken = 1'b0;
    case (w_cls)
      C_BRA, C_BRR: o_taken = w_any;
      C_BNE, C_BNR: o_taken = ~w_any;
      default:      o_taken = 1'b0;
    endcase
  end
endmodule

// File: rtl/sisc_ctrl_seq.sv
// Multicycle SISC control sequencer with short paths, hold, HALT and retire count.
// Optional SISC_CTRL_MEMWAIT_EN: MEM waits for dm_ack on LOD/STR/SWP.
module sisc_ctrl_seq
  import sisc_pkg::*;
#(
  parameter int OP_W   = 4,
  parameter int MM_W   = 4,
  parameter int STAT_W = 4,
  parameter int CNT_W  = 16,
  parameter int AM_IMM = AM_IMM_DEF
) (
  input logic            clk,
  input logic            rst_f,
  sisc_ctrl_seq_if.slave bus
);
  state_e           r_state, w_next;
  op_cls_e          w_cls;
  logic             w_taken, w_imm, w_mm0, w_hold, w_mem_done, w_memop;
  logic [CNT_W-1:0] r_retired;

  logic w_rf_we, w_ir_load, w_pc_write, w_pc_rst, w_dm_we;
  logic w_pc_sel, w_br_sel, w_rb_sel, w_mm_sel, w_rw_sel, w_illegal;
  logic [1:0] w_alu_op, w_wb_sel;

  assign w_cls   = decode_op(32'(bus.opcode));
  assign w_imm   = (bus.mm == MM_W'(AM_IMM));
  assign w_mm0   = (bus.mm == '0);
  assign w_memop = (w_cls == C_LOD) || (w_cls == C_STR) || (w_cls == C_SWP);
  assign w_hold  = bus.hold && (r_state != S_START0) && (r_state != S_HALT);

`ifdef SISC_CTRL_MEMWAIT_EN
  assign w_mem_done = bus.dm_ack;
`else
  assign w_mem_done = 1'b1;
`endif

  sisc_br_cond #(.OP_W(OP_W), .W(MM_W)) u_br_cond (
    .i_opcode (bus.opcode),
    .i_stat   (MM_W'(bus.stat)),
    .i_mm     (bus.mm),
    .o_taken  (w_taken)
  );

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) r_state <= S_START0;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!w_hold) begin
      case (r_state)
        S_START0:    w_next = S_START1;
        S_START1:    w_next = S_FETCH;
        S_FETCH:     w_next = S_DECODE;
        S_DECODE:    w_next = (w_cls == C_HLT) ? S_HALT :
                              (w_memop || w_cls == C_ALU) ? S_EXECUTE : S_FETCH;
        S_EXECUTE:   w_next = (w_cls == C_ALU) ? S_WRITEBACK :
                              w_memop ? S_MEM : S_FETCH;
        S_MEM: begin
          if (!w_memop)        w_next = S_FETCH;
          else if (w_mem_done) w_next = (w_cls == C_STR) ? S_FETCH : S_WRITEBACK;
        end
        S_WRITEBACK: w_next = S_FETCH;
        default:     w_next = S_HALT;
      endcase
    end
  end

  always_comb begin
    w_rf_we = 1'b0; w_ir_load = 1'b0; w_pc_write = 1'b0; w_pc_rst = 1'b0; w_dm_we = 1'b0;
    w_pc_sel = 1'b0; w_br_sel = 1'b0; w_rb_sel = 1'b0; w_mm_sel = 1'b0; w_rw_sel = 1'b1;
    w_alu_op = ALU_DEF; w_wb_sel = WB_ALU; w_illegal = 1'b0;
    case (r_state)
      S_START1: w_pc_rst = 1'b1;
      S_FETCH: begin
        w_ir_load  = 1'b1;
        w_pc_write = 1'b1;
      end
      S_DECODE: begin
        w_br_sel  = (w_cls == C_BRA) || (w_cls == C_BNE);
        w_illegal = (w_cls == C_ILL);
        if (w_taken) begin
          w_pc_sel   = 1'b1;
          w_pc_write = 1'b1;
        end
      end
      S_EXECUTE: begin
        if (w_cls == C_ALU) w_alu_op = w_imm ? ALU_IMM : ALU_REG;
        if (w_cls == C_LOD || w_cls == C_STR) begin
          w_alu_op = ALU_ADDR;
          w_mm_sel = w_mm0;
        end
      end
      S_MEM: begin
        if (w_cls == C_LOD || w_cls == C_STR) begin
          w_alu_op = ALU_ADDR;
          w_mm_sel = w_mm0;
        end
        if (w_cls == C_STR) begin
          w_rb_sel = 1'b1;
          w_dm_we  = 1'b1;
        end
        if (w_cls == C_SWP) begin
          w_rb_sel = 1'b1;
          w_wb_sel = WB_SWPA;
          w_rf_we  = 1'b1;
        end
      end
      S_WRITEBACK: begin
        w_rb_sel = 1'b1;
        case (w_cls)
          C_ALU: begin
            w_rf_we  = 1'b1;
            w_alu_op = w_imm ? ALU_IMM : ALU_REG;
          end
          C_LOD: begin
            w_rf_we  = 1'b1;
            w_wb_sel = WB_MEM;
            w_alu_op = ALU_ADDR;
            w_mm_sel = w_mm0;
          end
          C_SWP: begin
            w_rf_we  = 1'b1;
            w_rw_sel = 1'b0;
            w_wb_sel = WB_SWPB;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Stall kills every write strobe but leaves the datapath selects steady.
  assign bus.rf_we      = w_rf_we    & ~w_hold;
  assign bus.ir_load    = w_ir_load  & ~w_hold;
  assign bus.pc_write   = w_pc_write & ~w_hold;
  assign bus.pc_rst     = w_pc_rst   & ~w_hold;
  assign bus.dm_we      = w_dm_we    & ~w_hold;
  assign bus.pc_sel     = w_pc_sel;
  assign bus.br_sel     = w_br_sel;
  assign bus.rb_sel     = w_rb_sel;
  assign bus.mm_sel     = w_mm_sel;
  assign bus.rw_sel     = w_rw_sel;
  assign bus.alu_op     = w_alu_op;
  assign bus.wb_sel     = w_wb_sel;
  assign bus.illegal_op = w_illegal;
  assign bus.halted     = (r_state == S_HALT);
  assign bus.retired    = r_retired;

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f)
      r_retired <= '0;
    else if (w_next == S_FETCH &&
             (r_state == S_DECODE || r_state == S_MEM || r_state == S_WRITEBACK))
      r_retired <= r_retired + CNT_W'(1);
  end
endmodule

// File: tb/tb_sisc_ctrl_seq.sv
// Scoreboard bench for sisc_ctrl_seq: a cycle model pushes expected outputs,
// the negedge sampler pops and compares them.
module tb_sisc_ctrl_seq;
  localparam int M_S0 = 0, M_S1 = 1, M_F = 2, M_D = 3, M_E = 4, M_M = 5, M_W = 6, M_H = 7;

  typedef struct packed {
    logic [15:0] o;
    logic [15:0] r;
  } exp_t;

  logic clk = 1'b0;
  logic rst_f = 1'b1;
  always #5 clk = ~clk;

  sisc_ctrl_seq_if #(.OP_W(4), .MM_W(4), .STAT_W(4), .CNT_W(16)) bus();

  sisc_ctrl_seq #(.OP_W(4), .MM_W(4), .STAT_W(4), .CNT_W(16), .AM_IMM(8)) dut (
    .clk   (clk),
    .rst_f (rst_f),
    .bus   (bus)
  );

  exp_t        q[$];
  int          n_chk = 0, n_err = 0;
  int          m_st = M_S0;
  logic [15:0] m_ret = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_out(int st, logic [3:0] op, logic [3:0] mm,
                                            logic [3:0] stat, logic hold);
    logic rf, irl, pcw, pcr, dmw, pcs, brs, rbs, mms, rws, hlt, ill, tk;
    logic [1:0] alu, wb;
    rf = 0; irl = 0; pcw = 0; pcr = 0; dmw = 0; pcs = 0; brs = 0; rbs = 0; mms = 0;
    rws = 1; alu = 2'b10; wb = 2'b00; hlt = 0; ill = 0;
    tk = (op == 4 || op == 5) ? |(stat & mm) : (op == 6 || op == 7) ? ~|(stat & mm) : 1'b0;
    case (st)
      M_S1: pcr = 1;
      M_F:  begin irl = 1; pcw = 1; end
      M_D: begin
        brs = (op == 4 || op == 6);
        if (tk) begin pcs = 1; pcw = 1; end
        ill = !((op <= 8) || op == 15);
      end
      M_E: begin
        if (op == 8) alu = (mm == 8) ? 2'b01 : 2'b00;
        if (op == 1 || op == 2) begin alu = 2'b11; mms = (mm == 0); end
      end
      M_M: begin
        if (op == 1 || op == 2) begin alu = 2'b11; mms = (mm == 0); end
        if (op == 2) begin rbs = 1; dmw = 1; end
        if (op == 3) begin rbs = 1; wb = 2'b10; rf = 1; end
      end
      M_W: begin
        rbs = 1;
        if (op == 8) begin rf = 1; alu = (mm == 8) ? 2'b01 : 2'b00; end
        if (op == 1) begin rf = 1; wb = 2'b01; alu = 2'b11; mms = (mm == 0); end
        if (op == 3) begin rf = 1; rws = 0; wb = 2'b11; end
      end
      M_H: hlt = 1;
      default: ;
    endcase
    if (hold && st != M_S0 && st != M_H) begin
      rf = 0; irl = 0; pcw = 0; pcr = 0; dmw = 0;
    end
    return {rf, irl, pcw, pcr, dmw, pcs, brs, rbs, mms, rws, alu, wb, hlt, ill};
  endfunction

  function automatic int model_nxt(int st, logic [3:0] op, logic hold, logic ack);
    logic mop;
    mop = (op == 1 || op == 2 || op == 3);
    if (hold && st != M_S0 && st != M_H) return st;
    case (st)
      M_S0: return M_S1;
      M_S1: return M_F;
      M_F:  return M_D;
      M_D:  return (op == 15) ? M_H : (mop || op == 8) ? M_E : M_F;
      M_E:  return (op == 8) ? M_W : mop ? M_M : M_F;
      M_M:  return (mop && !ack) ? M_M : (op == 1 || op == 3) ? M_W : M_F;
      M_W:  return M_F;
      default: return M_H;
    endcase
  endfunction

  function automatic logic [15:0] obs_out();
    return {bus.rf_we, bus.ir_load, bus.pc_write, bus.pc_rst, bus.dm_we, bus.pc_sel,
            bus.br_sel, bus.rb_sel, bus.mm_sel, bus.rw_sel, bus.alu_op, bus.wb_sel,
            bus.halted, bus.illegal_op};
  endfunction

  task automatic sample(input string tag);
    exp_t e;
    e = q.pop_front();
    chk($sformatf("%s_outs_st%0d", tag, m_st), 32'(obs_out()), 32'(e.o));
    chk($sformatf("%s_retired", tag), 32'(bus.retired), 32'(e.r));
  endtask

  // One clock: drive at posedge+1, compare at negedge, advance model at posedge.
  task automatic cycle(input logic [3:0] op, input logic [3:0] mm, input logic [3:0] stat,
                       input logic hold, input logic ack);
    logic a;
    int   nx;
`ifdef SISC_CTRL_MEMWAIT_EN
    a = ack;
    bus.dm_ack = ack;
`else
    a = 1'b1;
    if (ack) a = 1'b1;
`endif
    bus.opcode = op; bus.mm = mm; bus.stat = stat; bus.hold = hold;
    q.push_back('{o: model_out(m_st, op, mm, stat, hold), r: m_ret});
    @(negedge clk);
    sample("cyc");
    @(posedge clk);
    nx = model_nxt(m_st, op, hold, a);
    if (nx == M_F && (m_st == M_D || m_st == M_M || m_st == M_W)) m_ret++;
    m_st = nx;
    #1;
  endtask

  task automatic do_reset();
    rst_f = 1'b0;
    m_st = M_S0;
    m_ret = '0;
    #1;
    q.push_back('{o: model_out(M_S0, bus.opcode, bus.mm, bus.stat, bus.hold), r: 16'd0});
    sample("rst");
    @(posedge clk);
    #1;
    rst_f = 1'b1;
  endtask

  task automatic boot();
    do_reset();
    cycle(4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    cycle(4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
  endtask

  // Runs one instruction from FETCH; hold applied for hn cycles in state hst,
  // dm_ack withheld for wn cycles in MEM. Loop bound caps a stuck DUT/model.
  task automatic run_instr(input logic [3:0] op, input logic [3:0] mm, input logic [3:0] stat,
                           input int hst, input int hn, input int wn);
    int   hc, wc;
    logic h, a;
    hc = 0; wc = 0;
    for (int k = 0; k < 16; k++) begin
      h = (m_st == hst) && (hc < hn);
      if (h) hc++;
      a = !((m_st == M_M) && (wc < wn));
      if (!a && !h) wc++;
      cycle(op, mm, stat, h, a);
      if (m_st == M_F || m_st == M_H) break;
    end
  endtask

  initial begin
    logic [3:0] ops[12];
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd12, 4'd8};
    bus.opcode = '0; bus.mm = '0; bus.stat = '0; bus.hold = 1'b0;
`ifdef SISC_CTRL_MEMWAIT_EN
    bus.dm_ack = 1'b1;
`endif
    #2;
    boot();
    // ALU immediate and register forms
    run_instr(4'd8, 4'd8, 4'd0, -1, 0, 0);
    run_instr(4'd8, 4'd3, 4'd0, -1, 0, 0);
    // BNE: masked bit clear -> taken; masked bit set -> not taken
    run_instr(4'd6, 4'b0001, 4'b0010, -1, 0, 0);
    run_instr(4'd6, 4'b0001, 4'b0011, -1, 0, 0);
    run_instr(4'd4, 4'b0100, 4'b0110, -1, 0, 0);
    run_instr(4'd5, 4'b1000, 4'b0111, -1, 0, 0);
    run_instr(4'd7, 4'b0000, 4'b1111, -1, 0, 0);
    // STR with a 3-cycle stall in MEM
    run_instr(4'd2, 4'd0, 4'd0, M_M, 3, 0);
    run_instr(4'd1, 4'd0, 4'd0, -1, 0, 0);
    run_instr(4'd1, 4'd5, 4'd0, M_W, 2, 0);
    run_instr(4'd3, 4'd2, 4'd0, M_E, 1, 0);
    run_instr(4'd0, 4'd0, 4'd0, M_D, 2, 0);
    run_instr(4'd9, 4'd0, 4'd0, -1, 0, 0);
    run_instr(4'd13, 4'd1, 4'd1, M_F, 1, 0);
`ifdef SISC_CTRL_MEMWAIT_EN
    run_instr(4'd1, 4'd5, 4'd0, -1, 0, 2);
    run_instr(4'd2, 4'd0, 4'd0, M_M, 1, 2);
    run_instr(4'd3, 4'd1, 4'd0, -1, 0, 1);
`endif
    for (int i = 0; i < 30; i++)
      run_instr(ops[$urandom_range(0, 11)], 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                $urandom_range(2, 7), $urandom_range(0, 2), $urandom_range(0, 2));
    // Reset while STR is in MEM with dm_we asserted
    cycle(4'd2, 4'd0, 4'd0, 1'b0, 1'b1);
    cycle(4'd2, 4'd0, 4'd0, 1'b0, 1'b1);
    cycle(4'd2, 4'd0, 4'd0, 1'b0, 1'b1);
    boot();
    run_instr(4'd8, 4'd8, 4'd0, -1, 0, 0);
    run_instr(4'd15, 4'd0, 4'd0, -1, 0, 0);
    for (int i = 0; i < 100; i++)
      cycle(4'($urandom_range(0, 15)), 4'd0, 4'd0, 1'($urandom_range(0, 1)), 1'b1);
    boot();
    run_instr(4'd8, 4'd1, 4'd0, -1, 0, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
